branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences control-flow redirection around the EX-stage branch unit. Holds a 2-bit
//  direction-prediction table for IF and checks each resolved branch/jump against the
//  next-PC that fetch actually followed. On a mismatch it flushes IF/ID and ID/EX and
//  drives a valid/ready redirect to the PC logic. Also trains the table and counts
//  mispredicts.
// PARAMETERS
//  BHT_IDX_W  6   table index width; BHT has 2**BHT_IDX_W entries, index = pc[BHT_IDX_W+1:2]
//  CNT_W      16  width of branch_cnt / mispred_cnt, saturating
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       synchronous active-low reset
//  if_pc        in   32      fetch PC for lookup
//  if_pred_taken out 1       MSB of BHT[if_pc idx], combinational read of registered table
//  ex_valid     in   1       EX holds a resolved control-flow op this cycle
//  ex_ready     out  1       controller accepts ex_* this cycle (=1 only in IDLE)
//  ex_pc        in   32      PC of the EX instruction
//  ex_is_branch in   1       conditional branch (BEQ..BGEU)
//  ex_is_jump   in   1       JAL/JALR (unconditional)
//  ex_taken     in   1       branch_taken from branch unit
//  ex_target    in   32      branch_target from branch unit (JALR LSB already cleared)
//  ex_pred_npc  in   32      next PC fetch actually used after ex_pc
//  redir_valid  out  1       redirect request to PC logic
//  redir_pc     out  32      correct next PC
//  redir_ready  in   1       PC logic accepts redirect
//  flush_if_id  out  1       squash IF/ID register
//  flush_id_ex  out  1       squash ID/EX register
//  branch_cnt   out  CNT_W   accepted conditional branches, saturates at all-ones
//  mispred_cnt  out  CNT_W   accepted mispredicts (branch or jump), saturates
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; redir_valid=0, redir_pc=0, flushes=0,
//    counters=0; every BHT entry=2'b01 (weakly not-taken). Reset mid-REDIR drops the request.
//  - accept = ex_valid & ex_ready & (ex_is_branch | ex_is_jump); ex_is_branch and
//    ex_is_jump both 0 -> no action.
//  - actual_npc = (ex_is_jump | ex_taken) ? ex_target : ex_pc + 32'd4 (mod 2^32).
//  - mispredict = accept & (actual_npc != ex_pred_npc).
//  - FSM IDLE: ex_ready=1. On mispredict -> REDIR at next edge, redir_pc<=actual_npc,
//    redir_valid<=1. Latency: 1 cycle from accept to redir_valid/flush.
//  - FSM REDIR: redir_valid=1, flush_if_id=flush_id_ex=1 every cycle, ex_ready=0
//    (ex_* ignored). redir_pc stable. redir_valid&redir_ready -> IDLE next edge,
//    redir_valid and flushes go 0 the next cycle. Ready held high on entry -> REDIR
//    lasts exactly 1 cycle.
//  - BHT update on accept & ex_is_branch only, at the clk edge:
//    ex_taken ? sat-inc (max 3) : sat-dec (min 0). Jumps never train.
//  - Same-cycle lookup and update of one index: if_pred_taken reflects the pre-update value
//    (no bypass).
//  - branch_cnt += accept&ex_is_branch; mispred_cnt += mispredict; both hold at 2^CNT_W-1.
//  - Table updates and counters are independent of FSM state. They act only on accepted ops.
// TESTING
//  1 reset then if_pc=0x1000 -> if_pred_taken=0; branch at 0x1000 taken twice -> pred=1
//    (01->10->11); not-taken once -> still 1 (10).
//  2 BEQ ex_pc=0x1000 taken, target=0x1100, pred_npc=0x1004 -> next cycle
//    redir_valid=1, redir_pc=0x1100, both flushes=1, mispred_cnt=1.
//  3 same as 2 with redir_ready=0 for 3 cycles -> redir_valid/flushes held 4 cycles,
//    ex_ready=0, ex_valid pulses in that window change neither counters nor BHT.
//  4 JALR ex_pc=0x2000, target=0x20FE, pred_npc=0x20FE -> no redirect; target=0x6
//    (wrap), pred_npc=0x2004 -> redir_pc=0x6; branch_cnt unchanged.
//  5 not-taken BNE ex_pc=0xFFFFFFFC, pred_npc=0x0 -> no mispredict (pc+4 wraps);
//    pred_npc=0x100 -> redir_pc=0x0.
//  6 rst_n=0 during REDIR -> next cycle redir_valid=0, counters=0, BHT entries read 01.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Handshake bundle between the EX branch unit, the redirect controller and the PC/pipeline logic.
// The controller takes the slave side: it accepts resolved ops and raises redirects/flushes.
interface branch_redirect_ctrl_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_npc;

    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        flush_if_id;
    logic        flush_id_ex;

    modport slave (
        input  ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target, ex_pred_npc,
        input  redir_ready,
        output ex_ready, redir_valid, redir_pc, flush_if_id, flush_id_ex
    );

    modport master (
        output ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target, ex_pred_npc,
        output redir_ready,
        input  ex_ready, redir_valid, redir_pc, flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: 2-bit BHT for fetch, EX-stage mispredict detection,
// redirect/flush sequencing to the PC logic, and saturating branch/mispredict counters.
module branch_redirect_ctrl #(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          if_pc_i,
    output logic                 if_pred_taken_o,
    output logic [CNT_W-1:0]     branch_cnt_o,
    output logic [CNT_W-1:0]     mispred_cnt_o,
    branch_redirect_ctrl_if.slave bus
);

    localparam int BHT_N = 2 ** BHT_IDX_W;

    typedef enum logic {
        IDLE,
        REDIR
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          redir_pc_q, redir_pc_d;
    logic [1:0]           bht_q [BHT_N];
    logic [1:0]           bht_cur, bht_d;
    logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

    logic [BHT_IDX_W-1:0] if_idx, ex_idx;
    logic                 ex_ready;
    logic                 accept;
    logic                 train;
    logic                 mispredict;
    logic [31:0]          actual_npc;
    logic                 unused_if_pc_bits;

    assign if_idx = if_pc_i[BHT_IDX_W+1:2];
    assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];
    assign unused_if_pc_bits = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0]};

    // Fetch sees the registered table only; a same-cycle update is visible next cycle.
    assign if_pred_taken_o = bht_q[if_idx][1];

    assign ex_ready   = (state_q == IDLE);
    assign accept     = bus.ex_valid & ex_ready & (bus.ex_is_branch | bus.ex_is_jump);
    assign train      = accept & bus.ex_is_branch;
    assign actual_npc = (bus.ex_is_jump | bus.ex_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
    assign mispredict = accept & (actual_npc != bus.ex_pred_npc);

    assign bus.ex_ready    = ex_ready;
    assign bus.redir_valid = (state_q == REDIR);
    assign bus.flush_if_id = (state_q == REDIR);
    assign bus.flush_id_ex = (state_q == REDIR);
    assign bus.redir_pc    = redir_pc_q;
    assign branch_cnt_o    = branch_cnt_q;
    assign mispred_cnt_o   = mispred_cnt_q;

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d    = REDIR;
                    redir_pc_d = actual_npc;
                end
            end
            REDIR: begin
                if (bus.redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating 2-bit counter step for the entry addressed by the EX instruction.
    always_comb begin
        bht_cur = bht_q[ex_idx];
        bht_d   = bht_cur;
        if (bus.ex_taken) begin
            if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train && branch_cnt_q != {CNT_W{1'b1}}) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && mispred_cnt_q != {CNT_W{1'b1}}) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            redir_pc_q    <= 32'd0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q       <= state_d;
            redir_pc_q    <= redir_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (train) begin
                bht_q[ex_idx] <= bht_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: inputs change on the falling edge and
// outputs are compared on the falling edge, away from the active rising edge.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
    int          errors = 0;
    int          checks = 0;

    branch_redirect_ctrl_if bus ();

    branch_redirect_ctrl #(
        .BHT_IDX_W (6),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc_i         (if_pc),
        .if_pred_taken_o (if_pred_taken),
        .branch_cnt_o    (branch_cnt),
        .mispred_cnt_o   (mispred_cnt),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveEx(input logic br, input logic jmp, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] npc);
        bus.ex_valid     = 1'b1;
        bus.ex_is_branch = br;
        bus.ex_is_jump   = jmp;
        bus.ex_taken     = tk;
        bus.ex_pc        = pc;
        bus.ex_target    = tgt;
        bus.ex_pred_npc  = npc;
    endtask

    // One op presented for one clock; returns at the following falling edge.
    task automatic applyStimulus(input logic br, input logic jmp, input logic tk,
                                 input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] npc);
        driveEx(br, jmp, tk, pc, tgt, npc);
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    task automatic checkRedir(input string tag, input logic exp);
        checkOutput({tag, "_valid"}, {31'd0, bus.redir_valid}, {31'd0, exp});
        checkOutput({tag, "_flush_if_id"}, {31'd0, bus.flush_if_id}, {31'd0, exp});
        checkOutput({tag, "_flush_id_ex"}, {31'd0, bus.flush_id_ex}, {31'd0, exp});
        checkOutput({tag, "_ex_ready"}, {31'd0, bus.ex_ready}, {31'd0, ~exp});
    endtask

    initial begin
        rst_n            = 1'b0;
        if_pc            = 32'h0;
        bus.ex_valid     = 1'b0;
        bus.ex_is_branch = 1'b0;
        bus.ex_is_jump   = 1'b0;
        bus.ex_taken     = 1'b0;
        bus.ex_pc        = 32'h0;
        bus.ex_target    = 32'h0;
        bus.ex_pred_npc  = 32'h0;
        bus.redir_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and BHT training at 0x1000.
        if_pc = 32'h1000;
        #1;
        checkRedir("rst", 1'b0);
        checkOutput("rst_redir_pc", bus.redir_pc, 32'h0);
        checkOutput("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        checkOutput("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        checkOutput("rst_pred", {31'd0, if_pred_taken}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1100);
        checkOutput("train_t1_pred", {31'd0, if_pred_taken}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1100);
        checkOutput("train_t2_pred", {31'd0, if_pred_taken}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, 32'h1100, 32'h1004);
        checkOutput("train_nt1_pred", {31'd0, if_pred_taken}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, 32'h1100, 32'h1004);
        checkOutput("train_nt2_pred", {31'd0, if_pred_taken}, 32'd0);
        checkRedir("train_no_redir", 1'b0);
        checkOutput("train_branch_cnt", {16'd0, branch_cnt}, 32'd4);
        checkOutput("train_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

        // Taken BEQ mispredicted as fall-through; lookup of the same index sees the old entry.
        driveEx(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1004);
        #1;
        checkOutput("nobypass_pred", {31'd0, if_pred_taken}, 32'd0);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        checkRedir("beq_redir", 1'b1);
        checkOutput("beq_redir_pc", bus.redir_pc, 32'h1100);
        checkOutput("beq_mispred_cnt", {16'd0, mispred_cnt}, 32'd1);
        checkOutput("beq_branch_cnt", {16'd0, branch_cnt}, 32'd5);
        checkOutput("beq_pred_after", {31'd0, if_pred_taken}, 32'd1);
        @(negedge clk);
        checkRedir("beq_done", 1'b0);

        // Redirect stalled by PC logic for three cycles; EX ops in the window are ignored.
        bus.redir_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1004);
        checkRedir("stall_c1", 1'b1);
        for (int k = 2; k <= 4; k++) begin
            driveEx(1'b1, 1'b0, 1'b1, 32'h1040, 32'h2000, 32'h1044);
            @(negedge clk);
            checkRedir($sformatf("stall_c%0d", k), 1'b1);
            checkOutput($sformatf("stall_pc_c%0d", k), bus.redir_pc, 32'h1100);
        end
        bus.ex_valid    = 1'b0;
        bus.redir_ready = 1'b1;
        @(negedge clk);
        checkRedir("stall_done", 1'b0);
        checkOutput("stall_branch_cnt", {16'd0, branch_cnt}, 32'd6);
        checkOutput("stall_mispred_cnt", {16'd0, mispred_cnt}, 32'd2);
        if_pc = 32'h1040;
        #1;
        checkOutput("stall_bht_untouched", {31'd0, if_pred_taken}, 32'd0);

        // Jumps: correct JALR, jumps never train, mispredicted JALR to a low target.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h2000, 32'h20FE, 32'h20FE);
        checkRedir("jalr_ok", 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1040, 32'h3000, 32'h3000);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1040, 32'h3000, 32'h3000);
        checkOutput("jal_no_train", {31'd0, if_pred_taken}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h2000, 32'h0000_0006, 32'h2004);
        checkRedir("jalr_bad", 1'b1);
        checkOutput("jalr_bad_pc", bus.redir_pc, 32'h6);
        checkOutput("jalr_branch_cnt", {16'd0, branch_cnt}, 32'd6);
        checkOutput("jalr_mispred_cnt", {16'd0, mispred_cnt}, 32'd3);
        @(negedge clk);

        // Op flagged as neither branch nor jump is not accepted.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000, 32'h4000, 32'h0);
        checkRedir("nop_op", 1'b0);
        checkOutput("nop_op_mispred_cnt", {16'd0, mispred_cnt}, 32'd3);

        // Not-taken branch at the top of the address space: pc+4 wraps to 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'h0);
        checkRedir("wrap_ok", 1'b0);
        checkOutput("wrap_ok_branch_cnt", {16'd0, branch_cnt}, 32'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'h100);
        checkRedir("wrap_bad", 1'b1);
        checkOutput("wrap_bad_pc", bus.redir_pc, 32'h0);
        checkOutput("wrap_bad_mispred_cnt", {16'd0, mispred_cnt}, 32'd4);
        checkOutput("wrap_bad_branch_cnt", {16'd0, branch_cnt}, 32'd8);
        @(negedge clk);

        // Reset in the middle of a stalled redirect drops it and clears the table.
        bus.redir_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1004);
        checkRedir("pre_rst_redir", 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkRedir("mid_rst", 1'b0);
        checkOutput("mid_rst_redir_pc", bus.redir_pc, 32'h0);
        checkOutput("mid_rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        checkOutput("mid_rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        if_pc = 32'h1000;
        #1;
        checkOutput("mid_rst_bht_1000", {31'd0, if_pred_taken}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1100, 32'h1100);
        checkOutput("mid_rst_bht_01_to_10", {31'd0, if_pred_taken}, 32'd1);
        bus.redir_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
